// File: rtl/jaa_pkg.sv
// Shared constants and reader state encoding for the instruction RAM reader.
package jaa_pkg;

    localparam int unsigned INSTRUCTION_WIDTH = 31;
    localparam int unsigned CURSOR_WIDTH      = 9;
    localparam int unsigned DEPTH             = 2 ** (CURSOR_WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } rd_state_e;

endpackage

// File: rtl/instr_ram.sv
// Single write port / single synchronous read port instruction RAM.
// Read-first: a same-cycle read and write of one address returns the old word.
module instr_ram
    import jaa_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       wr_en_i,
    input  logic [CURSOR_WIDTH:0]      wr_addr_i,
    input  logic [INSTRUCTION_WIDTH:0] wr_data_i,
    input  logic                       rd_en_i,
    input  logic [CURSOR_WIDTH:0]      rd_addr_i,
    output logic [INSTRUCTION_WIDTH:0] rd_data_o
);

    logic [INSTRUCTION_WIDTH:0] mem_q [DEPTH];
    logic [INSTRUCTION_WIDTH:0] rd_data_q;

    // Non-blocking read samples the array before the write lands.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_ram_reader.sv
// Instruction RAM with an append-only load port and a burst reader that streams
// a contiguous address range over valid/ready through a 2-entry output buffer.
module instr_ram_reader
    import jaa_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [INSTRUCTION_WIDTH:0] wr_instruction,
    output logic [CURSOR_WIDTH:0]      wr_cursor,
    input  logic                       start,
    input  logic [CURSOR_WIDTH:0]      start_addr,
    input  logic [CURSOR_WIDTH+1:0]    length,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTRUCTION_WIDTH:0] out_instruction,
    output logic [CURSOR_WIDTH:0]      out_addr,
    output logic                       busy,
    output logic                       done
);

    localparam logic [CURSOR_WIDTH:0]   CurOne = {{CURSOR_WIDTH{1'b0}}, 1'b1};
    localparam logic [CURSOR_WIDTH+1:0] LenOne = {{(CURSOR_WIDTH + 1){1'b0}}, 1'b1};

    rd_state_e                  state_q, state_d;
    logic [CURSOR_WIDTH:0]      wr_cursor_q, wr_cursor_d;
    logic [CURSOR_WIDTH:0]      rd_cursor_q, rd_cursor_d;
    logic [CURSOR_WIDTH+1:0]    issue_left_q, issue_left_d;
    logic [CURSOR_WIDTH+1:0]    out_left_q, out_left_d;
    logic                       done_q, done_d;
    logic                       inflight_q;
    logic [CURSOR_WIDTH:0]      inflight_addr_q;
    logic [INSTRUCTION_WIDTH:0] buf_data_q [2];
    logic [CURSOR_WIDTH:0]      buf_addr_q [2];
    logic                       head_q, tail_q;
    logic [1:0]                 count_q, count_d;
    logic [1:0]                 occupancy;
    logic                       issue, push, pop;
    logic [INSTRUCTION_WIDTH:0] rd_data;

    instr_ram u_instr_ram (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_cursor_q),
        .wr_data_i (wr_instruction),
        .rd_en_i   (issue),
        .rd_addr_i (rd_cursor_q),
        .rd_data_o (rd_data)
    );

    assign pop  = (count_q != 2'd0) && out_ready;
    assign push = inflight_q;
    // Counting this cycle's pop as free space is what lets a full-rate stream run bubble-free.
    assign occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue     = (state_q == StRead) && (issue_left_q != '0) && (occupancy < 2'd2);
    assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

    assign wr_cursor_d = wr_en ? wr_cursor_q + CurOne : wr_cursor_q;

    always_comb begin
        state_d      = state_q;
        rd_cursor_d  = rd_cursor_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        done_d       = 1'b0;
        if (pop) begin
            out_left_d = out_left_q - LenOne;
        end
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (length != '0) begin
                        state_d      = StRead;
                        rd_cursor_d  = start_addr;
                        issue_left_d = length;
                        out_left_d   = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRead: begin
                if (issue) begin
                    rd_cursor_d  = rd_cursor_q + CurOne;
                    issue_left_d = issue_left_q - LenOne;
                    if (issue_left_q == LenOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && (out_left_q == LenOne)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            wr_cursor_q     <= '0;
            rd_cursor_q     <= '0;
            issue_left_q    <= '0;
            out_left_q      <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            buf_data_q[0]   <= '0;
            buf_data_q[1]   <= '0;
            buf_addr_q[0]   <= '0;
            buf_addr_q[1]   <= '0;
            head_q          <= 1'b0;
            tail_q          <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q      <= state_d;
            wr_cursor_q  <= wr_cursor_d;
            rd_cursor_q  <= rd_cursor_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            done_q       <= done_d;
            inflight_q   <= issue;
            count_q      <= count_d;
            if (issue) begin
                inflight_addr_q <= rd_cursor_q;
            end
            if (push) begin
                buf_data_q[tail_q] <= rd_data;
                buf_addr_q[tail_q] <= inflight_addr_q;
                tail_q             <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

    assign out_valid       = (count_q != 2'd0);
    assign out_instruction = buf_data_q[head_q];
    assign out_addr        = buf_addr_q[head_q];
    assign busy            = (state_q != StIdle);
    assign done            = done_q;
    assign wr_cursor       = wr_cursor_q;

endmodule

// File: tb/tb_instr_ram_reader.sv
// Self-checking bench for instr_ram_reader: table of burst vectors plus hand-written
// sequences for zero-length starts and reset in the middle of a burst.
module tb_instr_ram_reader;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_instruction;
    logic [9:0]  wr_cursor;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] length;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [9:0]  out_addr;
    logic        busy;
    logic        done;

    instr_ram_reader dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_instruction  (wr_instruction),
        .wr_cursor       (wr_cursor),
        .start           (start),
        .start_addr      (start_addr),
        .length          (length),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_addr        (out_addr),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  sa;
        logic [10:0] len;
        logic [15:0] rdy;      // out_ready per cycle, bit (cycle % 16)
        bit          timing;   // check first-valid latency and bubble-free stream
        bit          poke;     // pulse start while busy
        bit          wr_same;  // write at the cursor on the first read edge
    } vec_t;

    int          tests;
    int          fails;
    logic [31:0] model [1024];
    logic [9:0]  wcur;
    vec_t        vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en          = 1'b1;
            wr_instruction = base + i;
            model[wcur]    = base + i;
            wcur           = wcur + 10'd1;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        int          got;
        int          first_v;
        int          last_x;
        bit          done_seen;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic [9:0]  prev_addr;
        logic [9:0]  exp_addr;
        logic [9:0]  gidx;
        got        = 0;
        first_v    = -1;
        last_x     = -1;
        done_seen  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_addr  = '0;
        @(negedge clk);
        start      = 1'b1;
        start_addr = v.sa;
        length     = v.len;
        out_ready  = 1'b0;
        for (int cyc = 0; cyc < int'(v.len) * 3 + 20 && !done_seen; cyc++) begin
            @(negedge clk);
            start          = v.poke && (cyc == 1);
            start_addr     = 10'd100;
            length         = 11'd5;
            wr_en          = v.wr_same && (cyc == 0);
            wr_instruction = 32'hBEEF_0005;
            if (done) begin
                done_seen = 1'b1;
                check("done_busy_low", busy, 0);
                check("done_no_valid", out_valid, 0);
                check("word_count", got, v.len);
            end else begin
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_instruction, prev_data);
                    check("stall_addr", out_addr, prev_addr);
                end
                if (out_valid && first_v < 0) first_v = cyc;
                out_ready = v.rdy[cyc % 16];
                if (out_valid && out_ready) begin
                    gidx     = got[9:0];
                    exp_addr = v.sa + gidx;
                    check("out_addr", out_addr, exp_addr);
                    check("out_data", out_instruction, model[exp_addr]);
                    got++;
                    last_x = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_instruction;
                prev_addr  = out_addr;
            end
        end
        start     = 1'b0;
        wr_en     = 1'b0;
        out_ready = 1'b0;
        check("done_seen", done_seen, 1);
        if (v.timing) begin
            check("first_valid_latency", first_v, 2);
            check("no_bubbles", last_x - first_v, v.len - 1);
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        if (v.wr_same) begin
            model[wcur] = 32'hBEEF_0005;
            wcur        = wcur + 10'd1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  xfers;
        bit  hit;
        tests = 0;
        fails = 0;
        wcur  = '0;
        vecs[0] = '{sa: 10'd0,    len: 11'd8,    rdy: 16'hFFFF, timing: 1, poke: 0, wr_same: 0};
        vecs[1] = '{sa: 10'd0,    len: 11'd8,    rdy: 16'h9999, timing: 0, poke: 0, wr_same: 0};
        vecs[2] = '{sa: 10'd1022, len: 11'd4,    rdy: 16'hFFFF, timing: 1, poke: 0, wr_same: 0};
        vecs[3] = '{sa: 10'd0,    len: 11'd1,    rdy: 16'hFFFF, timing: 1, poke: 0, wr_same: 0};
        vecs[4] = '{sa: 10'd5,    len: 11'd1,    rdy: 16'hFFFF, timing: 1, poke: 0, wr_same: 1};
        vecs[5] = '{sa: 10'd5,    len: 11'd1,    rdy: 16'hFFFF, timing: 0, poke: 0, wr_same: 0};
        vecs[6] = '{sa: 10'd10,   len: 11'd3,    rdy: 16'hFFF0, timing: 0, poke: 1, wr_same: 0};
        vecs[7] = '{sa: 10'd1020, len: 11'd6,    rdy: 16'h3333, timing: 0, poke: 0, wr_same: 0};
        vecs[8] = '{sa: 10'd5,    len: 11'd1024, rdy: 16'hF7BD, timing: 0, poke: 0, wr_same: 0};
        vecs[9] = '{sa: 10'd3,    len: 11'd2,    rdy: 16'hFFFF, timing: 1, poke: 0, wr_same: 0};

        rst            = 1'b1;
        wr_en          = 1'b0;
        wr_instruction = '0;
        start          = 1'b0;
        start_addr     = '0;
        length         = '0;
        out_ready      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr_cursor", wr_cursor, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_instr", out_instruction, 0);
        check("rst_out_addr", out_addr, 0);

        write_words(8, 32'hA000_0000);
        check("wr_cursor_8", wr_cursor, 8);
        for (int i = 0; i < 2; i++) run_burst(vecs[i]);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        wcur = '0;
        check("rst2_wr_cursor", wr_cursor, 0);
        write_words(1025, 32'd0);
        check("wr_cursor_wrap", wr_cursor, 1);
        write_words(4, 32'd1);
        check("wr_cursor_5", wr_cursor, 5);
        for (int i = 2; i < 9; i++) run_burst(vecs[i]);
        check("wr_cursor_after_same", wr_cursor, 6);

        // Zero-length start: no words, done one cycle later, never busy.
        @(negedge clk);
        start  = 1'b1;
        length = 11'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_valid", out_valid, 0);
        @(negedge clk);
        check("len0_done_drop", done, 0);
        check("len0_valid2", out_valid, 0);

        // Reset while the third word of a length-8 burst is presented.
        @(negedge clk);
        start      = 1'b1;
        start_addr = 10'd0;
        length     = 11'd8;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        xfers     = 0;
        hit       = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (out_valid) begin
                xfers++;
                if (xfers == 3) begin
                    rst = 1'b1;
                    #1;
                    hit = 1'b1;
                    check("mid_rst_valid", out_valid, 0);
                    check("mid_rst_busy", busy, 0);
                    check("mid_rst_done", done, 0);
                    check("mid_rst_addr", out_addr, 0);
                    check("mid_rst_instr", out_instruction, 0);
                end
            end
            if (!hit) @(negedge clk);
        end
        check("mid_rst_reached", hit, 1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        wcur      = '0;
        check("mid_rst_wr_cursor", wr_cursor, 0);
        @(negedge clk);
        check("mid_rst_still_idle", busy, 0);
        check("mid_rst_no_valid", out_valid, 0);
        run_burst(vecs[9]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
